// File: rtl/fan_speed_scheduler.sv
// Fan speed scheduler: drives the fan at the highest zone-requested level, ramping with step/hold timing.
// Optional manual override (forces level 3) is built when FAN_SCHED_OVERRIDE_EN is defined.
module fan_speed_scheduler #(
    parameter int NUM_ZONES   = 4,
    parameter int STEP_CYCLES = 16,
    parameter int HOLD_CYCLES = 256,
    localparam int OWNER_W    = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_ZONES-1:0]   req_valid,
    input  logic [2*NUM_ZONES-1:0] req_level,
    input  logic                   override_btn,
    output logic [1:0]             speed,
    output logic [1:0]             target,
    output logic [OWNER_W-1:0]     owner,
    output logic                   busy,
    output logic                   ovr_active
);

    localparam int MAX_CNT = (STEP_CYCLES > HOLD_CYCLES) ? STEP_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        STEADY    = 2'd0,
        UP        = 2'd1,
        DOWN_WAIT = 2'd2,
        DOWN      = 2'd3
    } state_t;

    state_t                      state;
    logic [CNT_W-1:0]            cnt;
    logic [NUM_ZONES-1:0][1:0]   lvl;
    logic [1:0]                  zone_max;
    logic [1:0]                  speed_up;
    logic [1:0]                  speed_dn;

    assign speed_up = speed + 2'd1;
    assign speed_dn = speed - 2'd1;
    assign busy     = (state != STEADY);

    always_comb begin
        zone_max = 2'd0;
        for (int i = 0; i < NUM_ZONES; i++) begin
            if (lvl[i] > zone_max) begin
                zone_max = lvl[i];
            end
        end
        target = ovr_active ? 2'd3 : zone_max;
    end

    // Scanning downward leaves the lowest matching zone index; all-zero levels resolve to zone 0.
    always_comb begin
        owner = '0;
        for (int i = NUM_ZONES - 1; i >= 0; i--) begin
            if (lvl[i] == target) begin
                owner = OWNER_W'(i);
            end
        end
        if (ovr_active) begin
            owner = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= STEADY;
            speed <= 2'd0;
            cnt   <= '0;
            lvl   <= '0;
        end else begin
            for (int i = 0; i < NUM_ZONES; i++) begin
                if (req_valid[i]) begin
                    lvl[i] <= req_level[2*i +: 2];
                end
            end

            case (state)
                STEADY: begin
                    if (target > speed) begin
                        speed <= speed_up;
                        cnt   <= '0;
                        state <= (speed_up == target) ? STEADY : UP;
                    end else if (target < speed) begin
                        cnt   <= '0;
                        state <= DOWN_WAIT;
                    end
                end
                UP: begin
                    if (target == speed) begin
                        cnt   <= '0;
                        state <= STEADY;
                    end else if (target < speed) begin
                        cnt   <= '0;
                        state <= DOWN_WAIT;
                    end else if (cnt == STEP_LAST) begin
                        speed <= speed_up;
                        cnt   <= '0;
                        if (speed_up == target) begin
                            state <= STEADY;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DOWN_WAIT: begin
                    if (target == speed) begin
                        cnt   <= '0;
                        state <= STEADY;
                    end else if (target > speed) begin
                        speed <= speed_up;
                        cnt   <= '0;
                        state <= (speed_up == target) ? STEADY : UP;
                    end else if (cnt == HOLD_LAST) begin
                        speed <= speed_dn;
                        cnt   <= '0;
                        state <= (speed_dn == target) ? STEADY : DOWN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DOWN: begin
                    if (target == speed) begin
                        cnt   <= '0;
                        state <= STEADY;
                    end else if (target > speed) begin
                        speed <= speed_up;
                        cnt   <= '0;
                        state <= (speed_up == target) ? STEADY : UP;
                    end else if (cnt == STEP_LAST) begin
                        speed <= speed_dn;
                        cnt   <= '0;
                        if (speed_dn == target) begin
                            state <= STEADY;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= STEADY;
                end
            endcase
        end
    end

`ifdef FAN_SCHED_OVERRIDE_EN
    logic btn;
    logic btn_prev;

    // A held button produces a single rising edge, so it toggles override only once.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            btn        <= 1'b0;
            btn_prev   <= 1'b0;
            ovr_active <= 1'b0;
        end else begin
            btn      <= override_btn;
            btn_prev <= btn;
            if (btn && !btn_prev) begin
                ovr_active <= !ovr_active;
            end
        end
    end
`else
    logic unused_override_btn;

    assign unused_override_btn = override_btn;
    assign ovr_active          = 1'b0;
`endif

endmodule

// File: tb/tb_fan_speed_scheduler.sv
// Scoreboard bench for fan_speed_scheduler: hand-derived per-edge expectations are queued
// with their edge number and compared on the falling edge after that rising edge.
module tb_fan_speed_scheduler;

    logic       clk;
    logic       reset_n;
    logic [3:0] req_valid;
    logic [7:0] req_level;
    logic       override_btn;
    logic [1:0] speed;
    logic [1:0] target;
    logic [1:0] owner;
    logic       busy;
    logic       ovr_active;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int cyc;
        int spd;
        int tgt;
        int own;
        int bsy;
        int ovr;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    fan_speed_scheduler #(
        .NUM_ZONES  (4),
        .STEP_CYCLES(4),
        .HOLD_CYCLES(8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_level   (req_level),
        .override_btn(override_btn),
        .speed       (speed),
        .target      (target),
        .owner       (owner),
        .busy        (busy),
        .ovr_active  (ovr_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    task automatic expectAt(input int c, input int s, input int t, input int o, input int b, input int v);
        exp_t e;
        e.cyc = c;
        e.spd = s;
        e.tgt = t;
        e.own = o;
        e.bsy = b;
        e.ovr = v;
        sb.push_back(e);
    endtask

    // Returns at the falling edge just before rising edge e.
    task automatic gotoEdge(input int e);
        while (cyc < e - 1) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [7:0] l);
        req_valid = v;
        req_level = l;
        @(negedge clk);
        req_valid = 4'b0000;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            if (cur.cyc != cyc) begin
                checkOutput($sformatf("late@%0d", cur.cyc), cyc, cur.cyc);
            end else begin
                checkOutput($sformatf("speed@%0d", cyc),  int'(speed),      cur.spd);
                checkOutput($sformatf("target@%0d", cyc), int'(target),     cur.tgt);
                checkOutput($sformatf("owner@%0d", cyc),  int'(owner),      cur.own);
                checkOutput($sformatf("busy@%0d", cyc),   int'(busy),       cur.bsy);
                checkOutput($sformatf("ovr@%0d", cyc),    int'(ovr_active), cur.ovr);
            end
        end
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog expired at edge %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t0;
        int t1;
        int s;
        int t;
        int o;
        int b;
        int v;

        // Reset held for edges 1 and 2 with random requests present.
        reset_n      = 1'b0;
        override_btn = 1'b0;
        req_valid    = 4'($urandom);
        req_level    = 8'($urandom);
        for (int e = 1; e <= 3; e++) expectAt(e, 0, 0, 0, 0, 0);
        gotoEdge(3);
        reset_n   = 1'b1;
        req_valid = 4'b0000;

        // Ramp-up then ramp-down with zone 2.
        t0 = 5;
        gotoEdge(t0);
        for (int r = 0; r <= 40; r++) begin
            s = (r < 1) ? 0 : (r < 5) ? 1 : (r < 9) ? 2 : (r < 29) ? 3 :
                (r < 33) ? 2 : (r < 37) ? 1 : 0;
            t = (r < 20) ? 3 : 0;
            o = (r < 20) ? 2 : 0;
            b = ((r >= 1 && r <= 8) || (r >= 21 && r <= 36)) ? 1 : 0;
            expectAt(t0 + r, s, t, o, b, 0);
        end
        applyStimulus(4'b0100, 8'h30);
        gotoEdge(t0 + 20);
        applyStimulus(4'b0100, 8'h00);

        // Reset asserted at edge 6 of a 0->3 ramp.
        t0 = t0 + 42;
        gotoEdge(t0);
        for (int r = 0; r <= 8; r++) begin
            if (r >= 6) expectAt(t0 + r, 0, 0, 0, 0, 0);
            else expectAt(t0 + r, (r < 1) ? 0 : (r < 5) ? 1 : 2, 3, 1, (r >= 1) ? 1 : 0, 0);
        end
        applyStimulus(4'b0010, 8'h0C);
        gotoEdge(t0 + 6);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Arbitration between zone 0 (level 1) and zone 3 (level 2).
        t0 = t0 + 10;
        gotoEdge(t0);
        for (int r = 0; r <= 19; r++) begin
            s = (r < 1) ? 0 : (r < 5) ? 1 : (r < 17) ? 2 : 1;
            t = (r < 8) ? 2 : 1;
            o = (r < 8) ? 3 : 0;
            b = ((r >= 1 && r <= 4) || (r >= 9 && r <= 16)) ? 1 : 0;
            expectAt(t0 + r, s, t, o, b, 0);
        end
        applyStimulus(4'b1001, 8'h81);
        gotoEdge(t0 + 8);
        applyStimulus(4'b1000, 8'h00);

        // Hold cancel: zone 2 drops to 2, re-requests 3 mid-hold, then drops to 2 again.
        t0 = t0 + 21;
        gotoEdge(t0);
        for (int r = 0; r <= 27; r++) begin
            s = (r < 1) ? 1 : (r < 5) ? 2 : (r < 25) ? 3 : 2;
            t = (r < 8) ? 3 : (r < 13) ? 2 : (r < 16) ? 3 : 2;
            b = ((r >= 1 && r <= 4) || (r >= 9 && r <= 13) || (r >= 17 && r <= 24)) ? 1 : 0;
            expectAt(t0 + r, s, t, 2, b, 0);
        end
        applyStimulus(4'b0100, 8'h30);
        gotoEdge(t0 + 8);
        applyStimulus(4'b0100, 8'h20);
        gotoEdge(t0 + 13);
        applyStimulus(4'b0100, 8'h30);
        gotoEdge(t0 + 16);
        applyStimulus(4'b0100, 8'h20);

        // All zones to 0, then exercise the override button.
        t0 = t0 + 29;
        gotoEdge(t0);
        for (int r = 0; r <= 14; r++) begin
            s = (r < 9) ? 2 : (r < 13) ? 1 : 0;
            b = (r >= 1 && r <= 12) ? 1 : 0;
            expectAt(t0 + r, s, 0, 0, b, 0);
        end
        applyStimulus(4'b1111, 8'h00);

        t1 = t0 + 16;
        gotoEdge(t1);
`ifdef FAN_SCHED_OVERRIDE_EN
        for (int r = 0; r <= 40; r++) begin
            v = (r >= 1 && r <= 20) ? 1 : 0;
            s = (r < 2) ? 0 : (r < 6) ? 1 : (r < 10) ? 2 : (r < 30) ? 3 :
                (r < 34) ? 2 : (r < 38) ? 1 : 0;
            b = ((r >= 2 && r <= 9) || (r >= 22 && r <= 37)) ? 1 : 0;
            expectAt(t1 + r, s, v ? 3 : 0, 0, b, v);
        end
        override_btn = 1'b1;
        repeat (5) @(negedge clk);
        override_btn = 1'b0;
        gotoEdge(t1 + 20);
        override_btn = 1'b1;
        repeat (2) @(negedge clk);
        override_btn = 1'b0;
`else
        for (int r = 0; r <= 12; r++) expectAt(t1 + r, 0, 0, 0, 0, 0);
        override_btn = 1'b1;
        repeat (5) @(negedge clk);
        override_btn = 1'b0;
`endif
        gotoEdge(t1 + 45);
        @(negedge clk);
        checkOutput("sb_drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
